regfile_operand_sequencer: RTL
==============================

Name: regfile_operand_sequencer

Overview:
- Initiator side of the 32x32 register array interface. Accepts decoded instructions (rs1/rs2/rd) over a valid/ready handshake and drives the array's read enables and write port.
- Captures operands A/B into an output register for the execute stage.
- Tracks pending writes in a busy-bit scoreboard, stalling RAW/WAW hazards.
- Forwards same-cycle writeback data when bypass is enabled.
- Sits between decode and execute/writeback in the core.

Parameters:
- BYPASS, 1: 1 forwards same-cycle writeback data to operand reads; 0 stalls until the write has landed.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decoded instruction valid
- issue_ready  out  1  sequencer accepts issue this cycle
- issue_rs1  in  5  source register A
- issue_rs2  in  5  source register B
- issue_rd  in  5  destination register
- issue_rd_we  in  1  instruction will write rd
- op_valid  out  1  operands valid to execute
- op_ready  in  1  execute accepts operands
- op_a  out  32  operand A
- op_b  out  32  operand B
- op_rd  out  5  destination, carried with the operands
- op_rd_we  out  1  write flag, carried with the operands
- wb_valid  in  1  writeback request (always accepted)
- wb_rd  in  5  writeback register
- wb_data  in  32  writeback data
- rf_enable_a  out  5  array read index A; equals issue_rs1
- rf_enable_b  out  5  array read index B; equals issue_rs2
- rf_select  out  5  array write index; equals wb_rd
- rf_store_data  out  32  array write data; equals wb_data
- rf_we  out  1  array write strobe; wb_valid && wb_rd != 0
- rf_a_bus  in  32  array read data A, combinational from rf_enable_a
- rf_b_bus  in  32  array read data B, combinational from rf_enable_b
- stall_count  out  CNT_W  cycles with issue_valid && !issue_ready

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - op_valid, op_a, op_b, op_rd, op_rd_we, busy[31:0] and stall_count all go to 0.
  - rf_* outputs stay combinational.
- Scoreboard:
  - busy[0] is hardwired 0.
  - wb_hit[r] = wb_valid && wb_rd == r.
  - Next busy[r] = (busy[r] && !wb_hit[r]) || set[r].
  - set[r] = issue accepted && issue_rd_we && issue_rd == r && r != 0.
  - If set and clear hit the same register in the same cycle, set wins.
- Source readiness:
  - src_rdy(r) = !busy[r] || (BYPASS && wb_hit[r]).
  - dst_rdy = !issue_rd_we || !busy[issue_rd] || wb_hit[issue_rd]. WAW clears on a same-cycle writeback regardless of BYPASS.
- issue_ready = (!op_valid || op_ready) && src_rdy(rs1) && src_rdy(rs2) && dst_rdy. It is combinational and must not depend on issue_valid.
- Accept (issue_valid && issue_ready), on the next edge:
  - op_valid <= 1.
  - op_a <= (rs1 == 0) ? 0 : (BYPASS && wb_hit[rs1]) ? wb_data : rf_a_bus. op_b is formed the same way from rs2 / rf_b_bus.
  - op_rd <= issue_rd. op_rd_we <= issue_rd_we && issue_rd != 0.
  - Operand latency is 1 cycle.
- Output holding:
  - op_valid drops on op_ready when there is no new accept in that cycle.
  - While op_valid && !op_ready, all op_* outputs hold stable.
  - Back-to-back accepts sustain 1 instruction per cycle when op_ready stays high.
- Writeback:
  - Always accepted. A write to x0 is dropped (rf_we = 0) and touches no state.
  - A write to a non-busy register still writes the array; the scoreboard is unchanged.
- stall_count increments each cycle with issue_valid && !issue_ready and saturates at all-ones.
- No combinational path from op_ready to op_* data.

Test Plan:
- Reset, then issue rs1=1, rs2=2, rd=3 (we=1), with the array holding x1=5, x2=7 and op_ready=1 → next cycle op_valid=1, op_a=5, op_b=7, op_rd=3; busy[3]=1.
- RAW stall: issue rd=3, then issue rs1=3 with no writeback → issue_ready=0 and stall_count counts 1,2,3. Then wb_rd=3, wb_data=0xDEAD_BEEF:
  - BYPASS=1 → accepted that cycle, op_a=0xDEADBEEF.
  - BYPASS=0 → accepted the following cycle.
- x0 handling: issue rs1=0, rd=0 (we=1), then wb_rd=0 → op_a=0, rf_we=0, busy stays 0, no stall.
- Backpressure: hold op_ready=0 for 3 cycles with issue_valid=1 → issue_ready=0 and op_* stable. Release → one accept per cycle.
- Same-cycle set/clear: busy[5]=1; issue rd=5 (we=1) together with wb_rd=5 → accepted, busy[5] stays 1.
- Reset asserted mid-stall with busy[3]=1 and op_valid=1 → immediately busy=0, op_valid=0, stall_count=0.

Source files
------------

// File: rtl/regfile_operand_sequencer.sv
// Operand sequencer between decode and execute/writeback.
// Reads two sources from the 32x32 register array, registers them for
// execute, and holds back instructions whose sources or destination still
// have a write pending in the busy-bit scoreboard.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Ready never depends on valid on the same side. A producer holding valid
// while ready is low must keep its payload stable. op_* hold while
// op_valid && !op_ready. Writeback has no ready and is always taken.
module regfile_operand_sequencer #(
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_we,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic [4:0]       op_rd,
    output logic             op_rd_we,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic [4:0]       rf_enable_a,
    output logic [4:0]       rf_enable_b,
    output logic [4:0]       rf_select,
    output logic [31:0]      rf_store_data,
    output logic             rf_we,
    input  logic [31:0]      rf_a_bus,
    input  logic [31:0]      rf_b_bus,
    output logic [CNT_W-1:0] stall_count,
    output logic [31:0]      busy_dbg
);

    logic [31:0]      busy_q, busy_d;
    logic [31:0]      wb_hit;
    logic [31:0]      set_vec;
    logic             op_valid_q, op_valid_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [4:0]       op_rd_q, op_rd_d;
    logic             op_rd_we_q, op_rd_we_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             src_rdy_a, src_rdy_b, dst_rdy;
    logic             accept;

    // Array ports are straight pass-throughs; x0 writes are suppressed.
    assign rf_enable_a   = issue_rs1;
    assign rf_enable_b   = issue_rs2;
    assign rf_select     = wb_rd;
    assign rf_store_data = wb_data;
    assign rf_we         = wb_valid && (wb_rd != 5'd0);

    // One-hot decode of the writeback target.
    always_comb begin
        wb_hit = '0;
        if (wb_valid) begin
            wb_hit[wb_rd] = 1'b1;
        end
    end

    // A source may bypass only in BYPASS builds; a WAW always clears on the
    // same-cycle writeback since the new write lands later anyway.
    assign src_rdy_a = !busy_q[issue_rs1] || (BYPASS && wb_hit[issue_rs1]);
    assign src_rdy_b = !busy_q[issue_rs2] || (BYPASS && wb_hit[issue_rs2]);
    assign dst_rdy   = !issue_rd_we || !busy_q[issue_rd] || wb_hit[issue_rd];

    assign issue_ready = (!op_valid_q || op_ready) && src_rdy_a && src_rdy_b && dst_rdy;
    assign accept      = issue_valid && issue_ready;

    // Next-state for scoreboard, operand register and stall counter.
    always_comb begin
        set_vec = '0;
        if (accept && issue_rd_we && (issue_rd != 5'd0)) begin
            set_vec[issue_rd] = 1'b1;
        end
        // Set is applied after clear so a same-cycle set wins.
        busy_d    = (busy_q & ~wb_hit) | set_vec;
        busy_d[0] = 1'b0;

        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_rd_d    = op_rd_q;
        op_rd_we_d = op_rd_we_q;
        if (accept) begin
            op_valid_d = 1'b1;
            if (issue_rs1 == 5'd0) begin
                op_a_d = '0;
            end else if (BYPASS && wb_hit[issue_rs1]) begin
                op_a_d = wb_data;
            end else begin
                op_a_d = rf_a_bus;
            end
            if (issue_rs2 == 5'd0) begin
                op_b_d = '0;
            end else if (BYPASS && wb_hit[issue_rs2]) begin
                op_b_d = wb_data;
            end else begin
                op_b_d = rf_b_bus;
            end
            op_rd_d    = issue_rd;
            op_rd_we_d = issue_rd_we && (issue_rd != 5'd0);
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end

        stall_d = stall_q;
        if (issue_valid && !issue_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            op_rd_we_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_rd_q    <= op_rd_d;
            op_rd_we_q <= op_rd_we_d;
            stall_q    <= stall_d;
        end
    end

    assign op_valid    = op_valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_rd       = op_rd_q;
    assign op_rd_we    = op_rd_we_q;
    assign stall_count = stall_q;
    assign busy_dbg    = busy_q;

endmodule
